// File: rtl/echo_request_input_if.sv
`default_nettype none
// ============================================================================
//  Module      : echo_request_input_if
//  Description : Bundles the echo request-side signals between the portal
//                request pipe, the messageSize query and the echo core.
//                slave  - view from echo_request_input (the deserializer)
//                master - view from its environment (host pipe + echo core)
//  Signals     : EN_requests_0_enq / requests_0_enq_v  host word push
//                RDY_requests_0_enq, RDY_requests_0_notFull, requests_0_notFull
//                messageSize_size_methodNumber -> messageSize_size (+ RDY)
//                EN_ifc_say / ifc_say_v, RDY_ifc_say
//                EN_ifc_sayPair / ifc_sayPair_a / ifc_sayPair_b, RDY_ifc_sayPair
//  Revision    : 1.0 - initial release
// ============================================================================
interface echo_request_input_if;
    logic        EN_requests_0_enq;
    logic [31:0] requests_0_enq_v;
    logic        RDY_requests_0_enq;
    logic        RDY_requests_0_notFull;
    logic        requests_0_notFull;
    logic [15:0] messageSize_size_methodNumber;
    logic        RDY_messageSize_size;
    logic [15:0] messageSize_size;
    logic        RDY_ifc_say;
    logic        EN_ifc_say;
    logic [31:0] ifc_say_v;
    logic        RDY_ifc_sayPair;
    logic        EN_ifc_sayPair;
    logic [31:0] ifc_sayPair_a;
    logic [31:0] ifc_sayPair_b;

    modport slave (
        input  EN_requests_0_enq, requests_0_enq_v, messageSize_size_methodNumber,
               RDY_ifc_say, RDY_ifc_sayPair,
        output RDY_requests_0_enq, RDY_requests_0_notFull, requests_0_notFull,
               RDY_messageSize_size, messageSize_size,
               EN_ifc_say, ifc_say_v, EN_ifc_sayPair, ifc_sayPair_a, ifc_sayPair_b
    );

    modport master (
        output EN_requests_0_enq, requests_0_enq_v, messageSize_size_methodNumber,
               RDY_ifc_say, RDY_ifc_sayPair,
        input  RDY_requests_0_enq, RDY_requests_0_notFull, requests_0_notFull,
               RDY_messageSize_size, messageSize_size,
               EN_ifc_say, ifc_say_v, EN_ifc_sayPair, ifc_sayPair_a, ifc_sayPair_b
    );
endinterface
`default_nettype wire

// File: rtl/echo_request_input.sv
`default_nettype none
// ============================================================================
//  Module      : echo_request_input
//  Description : Deserializes the host request word stream (header + payload)
//                into echo say / sayPair invocations, drops malformed
//                messages while counting them, and answers messageSize.
//  Ports       : CLK, RST        clock / synchronous active-high reset
//                bus (slave)     request pipe, messageSize, say, sayPair
//                error_count     saturating count of malformed messages
//  Revision    : 1.0 - initial release
// ============================================================================
module echo_request_input #(
    parameter logic [15:0] SAY_ID     = 16'd0,
    parameter logic [15:0] SAYPAIR_ID = 16'd1,
    parameter int          ERR_W      = 8
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    echo_request_input_if.slave   bus,
    output logic [ERR_W-1:0]      error_count
);

    localparam logic [15:0] c_SAY_WORDS  = 16'd2;
    localparam logic [15:0] c_PAIR_WORDS = 16'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_ISSUE   = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_is_pair;
    logic             r_second;
    logic [15:0]      r_remain;
    logic [15:0]      r_discard;
    logic [31:0]      r_say_v;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [ERR_W-1:0] r_err;

    logic             w_rdy_enq;
    logic             w_accept;
    logic [15:0]      w_hdr_method;
    logic [15:0]      w_hdr_count;
    logic             w_say_hdr;
    logic             w_pair_hdr;
    logic             w_fire_say;
    logic             w_fire_pair;

    assign w_rdy_enq    = (r_state != S_ISSUE);
    assign w_accept     = bus.EN_requests_0_enq & w_rdy_enq;
    assign w_hdr_method = bus.requests_0_enq_v[31:16];
    // A zero word count means a header-only message.
    assign w_hdr_count  = (bus.requests_0_enq_v[15:0] == 16'd0) ? 16'd1
                                                                : bus.requests_0_enq_v[15:0];
    assign w_say_hdr    = (w_hdr_method == SAY_ID)     && (w_hdr_count == c_SAY_WORDS);
    assign w_pair_hdr   = (w_hdr_method == SAYPAIR_ID) && (w_hdr_count == c_PAIR_WORDS);
    assign w_fire_say   = (r_state == S_ISSUE) & ~r_is_pair & bus.RDY_ifc_say;
    assign w_fire_pair  = (r_state == S_ISSUE) &  r_is_pair & bus.RDY_ifc_sayPair;

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_say_hdr || w_pair_hdr)  w_next_state = S_PAYLOAD;
                    else if (w_hdr_count > 16'd1) w_next_state = S_DISCARD;
                end
            end
            S_PAYLOAD: if (w_accept && (r_remain == 16'd1))  w_next_state = S_ISSUE;
            S_ISSUE:   if (w_fire_say || w_fire_pair)        w_next_state = S_IDLE;
            S_DISCARD: if (w_accept && (r_discard == 16'd1)) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_is_pair <= 1'b0;
            r_second  <= 1'b0;
            r_remain  <= 16'd0;
            r_discard <= 16'd0;
            r_say_v   <= 32'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_err     <= '0;
        end else if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (w_say_hdr || w_pair_hdr) begin
                        r_is_pair <= w_pair_hdr;
                        r_remain  <= w_hdr_count - 16'd1;
                        r_second  <= 1'b0;
                    end else begin
                        if (r_err != {ERR_W{1'b1}}) r_err <= r_err + 1'b1;
                        if (w_hdr_count > 16'd1)    r_discard <= w_hdr_count - 16'd1;
                    end
                end
                S_PAYLOAD: begin
                    r_remain <= r_remain - 16'd1;
                    r_second <= 1'b1;
                    if (r_second)       r_b     <= bus.requests_0_enq_v;
                    else if (r_is_pair) r_a     <= bus.requests_0_enq_v;
                    else                r_say_v <= bus.requests_0_enq_v;
                end
                S_DISCARD: r_discard <= r_discard - 16'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.messageSize_size = 16'd0;
        if (bus.messageSize_size_methodNumber == SAY_ID)
            bus.messageSize_size = 16'd32;
        else if (bus.messageSize_size_methodNumber == SAYPAIR_ID)
            bus.messageSize_size = 16'd64;
    end

    assign bus.RDY_requests_0_enq     = w_rdy_enq;
    assign bus.RDY_requests_0_notFull = 1'b1;
    assign bus.requests_0_notFull     = w_rdy_enq;
    assign bus.RDY_messageSize_size   = 1'b1;
    assign bus.EN_ifc_say             = w_fire_say;
    assign bus.ifc_say_v              = r_say_v;
    assign bus.EN_ifc_sayPair         = w_fire_pair;
    assign bus.ifc_sayPair_a          = r_a;
    assign bus.ifc_sayPair_b          = r_b;
    assign error_count                = r_err;

endmodule
`default_nettype wire
